// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_unit_pkg;

  // Fetch sequencer states: request outstanding, instruction held, timed out.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          DEF_TIMEOUT  = 16;

  // MIPS instruction field positions.
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 26;
  localparam int FUNCT_MSB    = 5;
  localparam int FUNCT_LSB    = 0;
  localparam int IMM16_MSB    = 15;
  localparam int IMM16_LSB    = 0;
  localparam int TARGET26_MSB = 25;
  localparam int TARGET26_LSB = 0;

  // Clears the byte-offset bits so every PC is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port of the fetch unit.
// Handshake: the fetch side raises Instr_Req with Instr_Addr and holds both
// stable until the memory answers; a cycle with Instr_Req=1 and Instr_Ack=1
// transfers Instr_Data. Instr_Ack is ignored whenever Instr_Req is low.
interface fetch_unit_if;
  logic        Instr_Req;
  logic [31:0] Instr_Addr;
  logic        Instr_Ack;
  logic [31:0] Instr_Data;

  modport master (output Instr_Req, Instr_Addr, input Instr_Ack, Instr_Data);
  modport slave  (input Instr_Req, Instr_Addr, output Instr_Ack, Instr_Data);
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// Next-PC selection: jump, taken branch, or fall through to PC+4.
module fetch_unit_next_pc_logic
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] branch_off;
  logic        unused_opcode;

  assign pc_plus4      = pc + 32'd4;
  assign imm16         = instr[IMM16_MSB:IMM16_LSB];
  assign target26      = instr[TARGET26_MSB:TARGET26_LSB];
  assign branch_off    = {{14{imm16[15]}}, imm16, 2'b00};
  // The opcode field is decoded by the control unit, not here.
  assign unused_opcode = ^instr[OPCODE_MSB:OPCODE_LSB];

  // Priority select: jump beats branch, branch needs Zero, else sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], target26, 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, fetches one word per instruction
// over a req/ack port, holds it for the control unit and steps the PC on Commit.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                CLK,
  input  logic                RST,
  fetch_unit_if.master        imem,
  input  logic                Commit,
  input  logic                Jump,
  input  logic                Branch,
  input  logic                Zero,
  output logic                Instr_Valid,
  output logic [31:0]         Instr,
  output logic [5:0]          Opcode,
  output logic [5:0]          Funct,
  output logic [31:0]         PC,
  output logic [31:0]         PCPlus4,
  output logic                Fault,
  output state_t              dbg_state
);

  localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [CW-1:0] wait_q, wait_d;
  // Low only during the first cycle after reset release, so the request
  // starts on a clean edge and drops asynchronously when reset asserts.
  logic          run_q, run_d;
  logic [31:0]   next_pc;

  fetch_unit_next_pc_logic u_next_pc_logic (
    .pc       (pc_q),
    .instr    (instr_q),
    .jump     (Jump),
    .branch   (Branch),
    .zero     (Zero),
    .pc_plus4 (PCPlus4),
    .next_pc  (next_pc)
  );

  // Next-state logic: capture on ack, count waits, step the PC on Commit.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    run_d   = 1'b1;
    case (state_q)
      ST_REQ: begin
        if (run_q) begin
          if (imem.Instr_Ack) begin
            instr_d = imem.Instr_Data;
            state_d = ST_HOLD;
          end else begin
            wait_d = wait_q + CW'(1);
            if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
              state_d = ST_FAULT;
            end
          end
        end
      end
      ST_HOLD: begin
        if (Commit) begin
          pc_d    = word_align(next_pc);
          wait_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_REQ;
      pc_q    <= word_align(RESET_PC);
      instr_q <= '0;
      wait_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      run_q   <= run_d;
    end
  end

  assign imem.Instr_Req  = run_q && (state_q == ST_REQ);
  assign imem.Instr_Addr = pc_q;
  assign Instr_Valid     = (state_q == ST_HOLD);
  assign Fault           = (state_q == ST_FAULT);
  assign Instr           = instr_q;
  assign Opcode          = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign Funct           = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign PC              = pc_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vectors plus randomized instruction streams
// checked against an arithmetic next-PC model and an expected-address queue.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          TO          = 16;
  localparam logic [31:0] HI_RESET_PC = 32'h8000_0023;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- shared stimulus ----------------
  logic        ack    = 1'b0;
  logic [31:0] data   = '0;
  logic        commit = 1'b0;
  logic        jump   = 1'b0;
  logic        branch = 1'b0;
  logic        zero   = 1'b0;
  logic        sel    = 1'b0;

  fetch_unit_if imem_lo ();
  fetch_unit_if imem_hi ();
  assign imem_lo.Instr_Ack  = ack;
  assign imem_lo.Instr_Data = data;
  assign imem_hi.Instr_Ack  = ack;
  assign imem_hi.Instr_Data = data;

  logic        lo_valid, hi_valid, lo_fault, hi_fault;
  logic [31:0] lo_instr, hi_instr, lo_pc, hi_pc, lo_pc4, hi_pc4;
  logic [5:0]  lo_opc, hi_opc, lo_fun, hi_fun;
  state_t      lo_state, hi_state;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) u_dut_lo (
    .CLK(CLK), .RST(RST), .imem(imem_lo),
    .Commit(commit), .Jump(jump), .Branch(branch), .Zero(zero),
    .Instr_Valid(lo_valid), .Instr(lo_instr), .Opcode(lo_opc), .Funct(lo_fun),
    .PC(lo_pc), .PCPlus4(lo_pc4), .Fault(lo_fault), .dbg_state(lo_state)
  );

  fetch_unit #(.RESET_PC(HI_RESET_PC), .TIMEOUT(TO)) u_dut_hi (
    .CLK(CLK), .RST(RST), .imem(imem_hi),
    .Commit(commit), .Jump(jump), .Branch(branch), .Zero(zero),
    .Instr_Valid(hi_valid), .Instr(hi_instr), .Opcode(hi_opc), .Funct(hi_fun),
    .PC(hi_pc), .PCPlus4(hi_pc4), .Fault(hi_fault), .dbg_state(hi_state)
  );

  // Observed view of whichever instance is under test.
  logic        obs_req, obs_valid, obs_fault;
  logic [31:0] obs_addr, obs_instr, obs_pc, obs_pc4;
  logic [5:0]  obs_opc, obs_fun;
  state_t      obs_state;
  assign obs_req   = sel ? imem_hi.Instr_Req  : imem_lo.Instr_Req;
  assign obs_addr  = sel ? imem_hi.Instr_Addr : imem_lo.Instr_Addr;
  assign obs_valid = sel ? hi_valid : lo_valid;
  assign obs_fault = sel ? hi_fault : lo_fault;
  assign obs_instr = sel ? hi_instr : lo_instr;
  assign obs_pc    = sel ? hi_pc    : lo_pc;
  assign obs_pc4   = sel ? hi_pc4   : lo_pc4;
  assign obs_opc   = sel ? hi_opc   : lo_opc;
  assign obs_fun   = sel ? hi_fun   : lo_fun;
  assign obs_state = sel ? hi_state : lo_state;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_pc    = '0;
  logic [31:0] ref_instr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference next-PC rule in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic j, input logic b, input logic z);
    logic [31:0] p4;
    int          offs;
    p4   = pc + 32'd4;
    offs = int'($signed(instr[15:0])) * 4;
    if (j) return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (b && z) return p4 + 32'(offs);
    return p4;
  endfunction

  // ---------------- driver tasks ----------------
  // Asserts reset mid-cycle (no clock edge), checks the asynchronous drop,
  // releases it and checks the reset state one cycle later.
  task automatic apply_reset(input logic [31:0] rpc);
    @(negedge CLK);
    #2;
    RST = 1'b0; ack = 1'b0; commit = 1'b0;
    #1;
    check("rst_req_async", obs_req, 1'b0);
    check("rst_valid_async", obs_valid, 1'b0);
    @(negedge CLK);
    check("rst_fault", obs_fault, 1'b0);
    check("rst_instr", obs_instr, 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_req", obs_req, 1'b1);
    check("rst_addr", obs_addr, rpc);
    check("rst_valid", obs_valid, 1'b0);
    check("rst_fault_rel", obs_fault, 1'b0);
    check("rst_state", obs_state, ST_REQ);
    ref_pc = rpc;
    exp_q.delete();
  endtask

  // Serves the outstanding request after 'waits' idle cycles, with Commit
  // noise that must be ignored while the request is pending.
  task automatic fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      ack = 1'b0; data = $urandom;
      commit = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      check("wait_req", obs_req, 1'b1);
      check("wait_addr", obs_addr, ref_pc);
      check("wait_valid", obs_valid, 1'b0);
      @(negedge CLK);
    end
    check("ack_req", obs_req, 1'b1);
    check("ack_addr", obs_addr, ref_pc);
    ack = 1'b1; data = word; commit = 1'($urandom_range(0, 1));
    @(negedge CLK);
    ack = 1'b0; commit = 1'b0;
    ref_instr = word;
    check("hold_valid", obs_valid, 1'b1);
    check("hold_req", obs_req, 1'b0);
    check("hold_instr", obs_instr, word);
    check("hold_opcode", obs_opc, word >> 26);
    check("hold_funct", obs_fun, word & 32'h3F);
    check("hold_pc", obs_pc, ref_pc);
    check("hold_pc4", obs_pc4, ref_pc + 32'd4);
  endtask

  // Stays in HOLD with stray acks that must not disturb the instruction.
  task automatic dwell(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      commit = 1'b0; ack = 1'($urandom_range(0, 1)); data = $urandom;
      @(negedge CLK);
      check("dwell_valid", obs_valid, 1'b1);
      check("dwell_instr", obs_instr, ref_instr);
      check("dwell_req", obs_req, 1'b0);
    end
    ack = 1'b0;
  endtask

  task automatic do_commit(input logic j, input logic b, input logic z);
    logic [31:0] exp;
    exp_q.push_back(model_next(ref_pc, ref_instr, j, b, z));
    commit = 1'b1; jump = j; branch = b; zero = z;
    @(negedge CLK);
    commit = 1'b0;
    jump = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
    exp = exp_q.pop_front();
    check("commit_req", obs_req, 1'b1);
    check("commit_valid", obs_valid, 1'b0);
    check("next_addr", obs_addr, exp);
    check("next_pc", obs_pc, exp);
    ref_pc = exp;
  endtask

  task automatic random_stream(input int n);
    for (int k = 0; k < n; k++) begin
      fetch($urandom, $urandom_range(0, 5));
      dwell($urandom_range(0, 2));
      do_commit(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;

    apply_reset(32'h0);

    // Directed vectors.
    fetch(32'h2008_0005, 0);
    check("opcode_addi", obs_opc, 6'h08);
    check("pc_first", obs_pc, 32'h0);
    do_commit(1'b0, 1'b0, 1'b0);
    check("seq_to_4", obs_addr, 32'h4);
    fetch(32'h0800_0004, 1);
    do_commit(1'b1, 1'b0, 1'b0);
    check("jump_to_10", obs_addr, 32'h10);
    fetch(32'h1109_FFFE, 3);
    dwell(2);
    do_commit(1'b0, 1'b1, 1'b1);
    check("br_taken", obs_addr, 32'h0C);
    fetch(32'h0800_0004, 0);
    do_commit(1'b1, 1'b0, 1'b0);
    check("jump_back_10", obs_addr, 32'h10);
    fetch(32'h1109_FFFE, 0);
    do_commit(1'b0, 1'b1, 1'b0);
    check("br_not_taken", obs_addr, 32'h14);
    // Ack on the last cycle before the timeout still succeeds.
    fetch(32'h0000_0020, TO - 1);
    do_commit(1'b0, 1'b0, 1'b0);
    check("late_ack_seq", obs_addr, 32'h18);

    random_stream(40);

    // Backward branch below zero, then sequential wrap.
    apply_reset(32'h0);
    fetch(32'h1000_FFFE, 0);
    do_commit(1'b0, 1'b1, 1'b1);
    check("br_to_top", obs_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0);
    check("pc4_wrap", obs_pc4, 32'h0);
    do_commit(1'b0, 1'b0, 1'b0);
    check("seq_wrap", obs_addr, 32'h0);
    fetch(32'h0800_0004, 0);
    do_commit(1'b1, 1'b1, 1'b1);
    check("jump_prio", obs_addr, 32'h10);

    // Timeout: count request cycles with no ack, bounded.
    ack = 1'b0;
    cnt = 0;
    while (obs_req === 1'b1 && cnt < 4 * TO) begin
      cnt++;
      commit = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    check("req_cycles", cnt, TO);
    check("fault_set", obs_fault, 1'b1);
    check("fault_req", obs_req, 1'b0);
    check("fault_valid", obs_valid, 1'b0);
    check("fault_state", obs_state, ST_FAULT);
    commit = 1'b1; jump = 1'b1; ack = 1'b1; data = $urandom;
    repeat (3) @(negedge CLK);
    commit = 1'b0; ack = 1'b0;
    check("fault_sticky", obs_fault, 1'b1);
    check("fault_req_off", obs_req, 1'b0);
    check("fault_pc", obs_pc, ref_pc);

    // Reset from FAULT, during REQ, and during HOLD.
    apply_reset(32'h0);
    apply_reset(32'h0);
    fetch(32'h0123_4567, 1);
    apply_reset(32'h0);

    // High-address instance: alignment of RESET_PC and jump in upper segment.
    sel = 1'b1;
    apply_reset(32'h8000_0020);
    fetch(32'h0800_0004, 2);
    do_commit(1'b1, 1'b0, 1'b0);
    check("jump_hi", obs_addr, 32'h8000_0010);
    random_stream(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end for the single-cycle MIPS core, sitting between instruction memory and the control unit. It owns the PC, issues word-read requests to a variable-latency instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. It presents Opcode/Funct to the control unit and consumes the decoded Jump/Branch controls plus the ALU Zero flag to compute the next PC. A sticky fault flags a memory that never acknowledges.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] are forced to 00.
- TIMEOUT, 16, maximum request cycles without ack before fault; 0 disables the timeout.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- Instr_Req  out  1  read request to instruction memory.
- Instr_Addr  out  32  byte address of the requested word (equals PC).
- Instr_Ack  in  1  memory has Instr_Data valid this cycle.
- Instr_Data  in  32  fetched instruction word.
- Commit  in  1  datapath has executed the held instruction; load the next PC.
- Jump  in  1  from control unit.
- Branch  in  1  from control unit.
- Zero  in  1  ALU zero flag.
- Instr_Valid  out  1  Instr/Opcode/Funct hold a live instruction.
- Instr  out  32  instruction register.
- Opcode  out  6  Instr[31:26].
- Funct  out  6  Instr[5:0].
- PC  out  32  address of the held instruction.
- PCPlus4  out  32  PC + 4, modulo 2^32.
- Fault  out  1  sticky timeout flag.

## Operation
- States:
  - REQ: request outstanding.
  - HOLD: instruction valid.
  - FAULT: request timed out.
- Reset: state REQ, PC=RESET_PC, Instr=0, wait counter=0, Fault=0.
  - Instr_Req rises on the first cycle after reset release.
  - Instr_Valid=0.
- REQ:
  - Instr_Req=1 and Instr_Addr=PC, both held stable until ack.
  - On Instr_Ack: capture Instr_Data into Instr and go to HOLD.
  - Otherwise, increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack, go to FAULT. Instr_Req is therefore high for exactly TIMEOUT cycles.
- HOLD:
  - Instr_Req=0, Instr_Valid=1.
  - On Commit, PC is loaded with the next PC, selected in priority order:
    - Jump: {PCPlus4[31:28], Instr[25:0], 2'b00}.
    - Branch & Zero: PCPlus4 + (sign-extended Instr[15:0] << 2), modulo 2^32.
    - Otherwise: PCPlus4.
  - Then clear the wait counter and go to REQ.
- FAULT:
  - Instr_Req=0, Instr_Valid=0, Fault=1.
  - Left only by reset.
- Ignored inputs:
  - Instr_Ack outside REQ.
  - Commit, Jump, Branch and Zero outside HOLD.
- Bubble behaviour: Instr retains its last value while Instr_Valid=0. The datapath must gate RegWrite/MemWrite with Instr_Valid.
- PC[1:0] is always 00.

## Timing
- Ack in the same cycle as the request (cycle k): Instr_Valid=1 and Instr updated at cycle k+1.
- Ack after N wait cycles: valid N+1 cycles after the request cycle.
- Commit sampled at cycle m: Instr_Addr = new PC and Instr_Req=1 at cycle m+1.
- Minimum cost is 2 cycles per instruction.
- All outputs are registered or decoded directly from state/PC/Instr. There is no combinational path from Instr_Ack or Commit to Instr_Req.
- Reset asserted mid-request: Instr_Req drops asynchronously. Any in-flight ack arriving after reset release is not expected; memory must cancel on reset.

## Structure
- Shared package holds:
  - the state typedef (REQ, HOLD, FAULT);
  - the RESET_PC and TIMEOUT defaults;
  - the instruction field slice positions (opcode, funct, imm16, target26).
- One combinational sub-module, Next_PC_Logic: inputs PC, Instr, Jump, Branch, Zero; outputs PCPlus4 and the next PC.

## Test plan
- Reset, RESET_PC=0: after release, Instr_Req=1, Instr_Addr=0, Instr_Valid=0, Fault=0.
- Sequential fetch: ack same cycle with 32'h2008_0005. Next cycle: Instr_Valid=1, Opcode=6'h08, PC=0. Commit with Jump=Branch=0 → next cycle Instr_Addr=32'h4.
- Branch at PC=32'h10 with Instr=32'h1109_FFFE:
  - Branch=1, Zero=1, Commit → Instr_Addr=32'h0C.
  - Repeated with Zero=0 → Instr_Addr=32'h14.
- Jump at PC=32'h8000_0020 with Instr=32'h0800_0004, Jump=1, Commit → Instr_Addr=32'h8000_0010. Also check PC=32'hFFFF_FFFC sequential wraps to 32'h0.
- Wait states and timeout (TIMEOUT=16):
  - Ack after 3 cycles: Instr_Addr stable throughout, valid at the 4th cycle after the request.
  - No ack: Instr_Req high exactly 16 cycles, then Fault=1 and Instr_Req=0. Commit is ignored.
- Async reset during REQ and during HOLD: Instr_Req and Instr_Valid go to 0 immediately. After release, Instr_Addr=RESET_PC and Fault=0.
